// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction-fetch and data ports.
// Optional one-entry fetch buffer enabled by defining ARB_IBUF_EN.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_stall
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          if_win;
  logic          dm_win;
  logic          ibuf_hit;
  logic          acc_done;

`ifdef ARB_IBUF_EN
  logic          ibuf_vld;
  logic [AW-3:0] ibuf_tag;
  logic [DW-1:0] ibuf_data;
  assign ibuf_hit = ibuf_vld && (ibuf_tag == if_addr[AW-1:2]);
`else
  assign ibuf_hit = 1'b0;
`endif

  assign if_win    = if_req && ((starve_cnt == SMAX) || !dm_req);
  assign dm_win    = !if_win && dm_req;
  assign acc_done  = mem_ack && mem_en;
  assign mem_stall = (if_req && !if_ready) || (dm_req && !dm_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (if_win)      state_nxt = ibuf_hit ? DONE : INST;
        else if (dm_win) state_nxt = DATA;
      end
      DATA, INST: if (acc_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant / completion stage: memory handshake, ready pulses, read-data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            starve_cnt <= '0;
            if (ibuf_hit) begin
`ifdef ARB_IBUF_EN
              if_rdata <= ibuf_data;
`endif
              if_ready <= 1'b1;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end else if (dm_win) begin
            if (if_req && (starve_cnt != SMAX)) starve_cnt <= starve_cnt + CW'(1);
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end
        end
        DATA, INST: begin
          if (acc_done) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == INST) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= mem_rdata;
              dm_ready <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_IBUF_EN
  // Fetch buffer: any granted store may alias the cached line, so it clears validity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ibuf_vld <= 1'b0;
    end else if ((state == IDLE) && dm_win && dm_we) begin
      ibuf_vld <= 1'b0;
    end else if ((state == INST) && acc_done) begin
      ibuf_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == INST) && acc_done) begin
      ibuf_tag  <= mem_addr[AW-1:2];
      ibuf_data <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a latency-programmable memory model.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_stall;

  int n_cmp = 0;
  int n_bad = 0;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: ack driven mem_lat edges after mem_en is first seen high
  logic          model_on = 1'b1;
  int            mem_lat = 1;
  logic [DW-1:0] rd_val = '0;
  int            mcnt = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (model_on) begin
      if (!reset_n) begin
        mem_ack = 1'b0;
        mcnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_en) begin
        if (mcnt == mem_lat) begin
          mem_ack = 1'b1;
          mem_rdata = rd_val;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

`ifdef ARB_IBUF_EN
  task automatic access(input logic is_if, input logic we, input logic [31:0] a,
                        output int rdy, output int ens);
    if (is_if) begin if_req = 1'b1; if_addr = a; end
    else begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = 32'h0000_0077; end
    rdy = -1;
    ens = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (mem_en) ens++;
      if ((is_if && if_ready) || (!is_if && dm_ready)) begin rdy = i; break; end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick;
  endtask
`endif

  initial begin
    int g;
    int en_cnt;
    int rdy_at;
    logic prev_en;
    logic [31:0] gaddr [5];

    // Reset
    tick; tick;
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset_n = 1'b1;
    tick;
    chk("rst_rel_outs", {26'b0, mem_en, mem_we, if_ready, dm_ready, mem_stall, 1'b0}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_wdata, 32'd0);

    // Lone fetch, L=1
    rd_val = 32'h2000_0005;
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("lone_stall", {31'b0, mem_stall}, 32'd1);
    tick;
    chk("lone_en", {30'b0, mem_en, mem_we}, 32'b10);
    chk("lone_addr", mem_addr, 32'h100);
    tick;
    chk("lone_rdy_early", {31'b0, if_ready}, 32'd0);
    tick;
    chk("lone_rdy", {30'b0, if_ready, mem_en}, 32'b10);
    chk("lone_rdata", if_rdata, 32'h2000_0005);
    chk("lone_stall_off", {31'b0, mem_stall}, 32'd0);
    if_req = 1'b0;
    tick;
    chk("lone_pulse", {31'b0, if_ready}, 32'd0);
    chk("lone_hold", if_rdata, 32'h2000_0005);

    // Collision: store wins, fetch follows
    rd_val = 32'h1111_2222;
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    tick;
    chk("col_st_we", {30'b0, mem_en, mem_we}, 32'b11);
    chk("col_st_addr", mem_addr, 32'h40);
    chk("col_st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("col_stall0", {31'b0, mem_stall}, 32'd1);
    tick;
    tick;
    chk("col_dm_rdy", {30'b0, dm_ready, if_ready}, 32'b10);
    chk("col_stall1", {31'b0, mem_stall}, 32'd1);
    chk("col_st_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    tick;
    chk("col_stall2", {31'b0, mem_stall}, 32'd1);
    tick;
    chk("col_if_en", {30'b0, mem_en, mem_we}, 32'b10);
    chk("col_if_addr", mem_addr, 32'h104);
    tick;
    tick;
    chk("col_if_rdy", {31'b0, if_ready}, 32'd1);
    chk("col_if_rdata", if_rdata, 32'h1111_2222);
    if_req = 1'b0;
    tick;

    // Starvation: four data grants then a forced fetch grant
    rd_val = 32'h3333_4444;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h108;
    g = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 5; i++) gaddr[i] = '0;
    for (int i = 0; i < 80 && g < 5; i++) begin
      tick;
      if (mem_en && !prev_en) begin gaddr[g] = mem_addr; g++; end
      prev_en = mem_en;
    end
    chk("stv_grants", g, 5);
    for (int i = 0; i < 4; i++) chk($sformatf("stv_dm%0d", i), gaddr[i], 32'h80);
    chk("stv_if5", gaddr[4], 32'h108);
    chk("stv_dm_rdata", dm_rdata, 32'h3333_4444);
    for (int i = 0; i < 20 && !if_ready; i++) tick;
    chk("stv_if_rdy", {31'b0, if_ready}, 32'd1);
    if_req = 1'b0; dm_req = 1'b0;
    tick;

    // Slow memory, L=7
    mem_lat = 7;
    rd_val = 32'h5555_6666;
    if_req = 1'b1; if_addr = 32'h10C;
    en_cnt = 0;
    rdy_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (mem_en && mem_addr == 32'h10C) en_cnt++;
      if (if_ready) begin rdy_at = i; break; end
    end
    chk("slow_en_cycles", en_cnt, 32'd8);
    chk("slow_rdy_at", rdy_at, 32'd8);
    chk("slow_rdata", if_rdata, 32'h5555_6666);
    if_req = 1'b0;
    tick;
    mem_lat = 1;

    // Reset during an access; the late ack must be ignored
    model_on = 1'b0;
    mem_ack = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    tick;
    chk("abt_en", {31'b0, mem_en}, 32'd1);
    tick; tick;
    reset_n = 1'b0;
    dm_req = 1'b0;
    #1 chk("abt_async", {30'b0, mem_en, dm_ready}, 32'd0);
    tick;
    reset_n = 1'b1;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_0BAD;
    tick;
    mem_ack = 1'b0;
    chk("abt_no_rdy", {30'b0, dm_ready, mem_en}, 32'd0);
    tick;
    chk("abt_no_rdy2", {31'b0, dm_ready}, 32'd0);
    chk("abt_rdata", dm_rdata, 32'd0);
    model_on = 1'b1;
    tick;

`ifdef ARB_IBUF_EN
    begin
      int rdy, ens;
      rd_val = 32'h7777_8888;
      access(1'b1, 1'b0, 32'h100, rdy, ens);
      chk("ib_miss_en", ens, 32'd2);
      access(1'b1, 1'b0, 32'h100, rdy, ens);
      chk("ib_hit_en", ens, 32'd0);
      chk("ib_hit_rdy", rdy, 32'd0);
      chk("ib_hit_data", if_rdata, 32'h7777_8888);
      access(1'b0, 1'b1, 32'h200, rdy, ens);
      chk("ib_st_rdy", rdy, 32'd2);
      access(1'b1, 1'b0, 32'h100, rdy, ens);
      chk("ib_inv_en", ens, 32'd2);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
